// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states,
// instruction field positions and flag bit indices.
package alu_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SRA  = 4'h8,
        OP_IDLE = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int RD_MSB = 27;
    localparam int RD_LSB = 23;
    localparam int RS_MSB = 22;
    localparam int RS_LSB = 18;
    localparam int RT_MSB = 17;
    localparam int RT_LSB = 13;

    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, a debug read port and one write
// stage in which an ALU writeback overrides a host write to the same register.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [XLEN-1:0]   rs_data_o,
    output logic [XLEN-1:0]   rt_data_o,
    output logic [XLEN-1:0]   dbg_data_o,
    input  logic              alu_we_i,
    input  logic [REG_AW-1:0] alu_waddr_i,
    input  logic [XLEN-1:0]   alu_wdata_i,
    input  logic              host_we_i,
    input  logic [REG_AW-1:0] host_waddr_i,
    input  logic [XLEN-1:0]   host_wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset because registers must read 0 after reset; this keeps it in flops, not a RAM macro.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            // r0 is never written, so it keeps its reset value of 0.
            for (int i = 1; i < NREGS; i++) begin
                if (alu_we_i && alu_waddr_i == REG_AW'(i)) begin
                    regs_q[i] <= alu_wdata_i;
                end else if (host_we_i && host_waddr_i == REG_AW'(i)) begin
                    regs_q[i] <= host_wdata_i;
                end
            end
        end
    end

    assign rs_data_o  = regs_q[rs_addr_i];
    assign rt_data_o  = regs_q[rt_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for a registered ALU: accepts one R-format instruction,
// presents operands for one cycle, then writes back the result and flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              hwr_en,
    input  logic [REG_AW-1:0] hwr_addr,
    input  logic [XLEN-1:0]   hwr_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic [3:0]        alu_opcode,
    output logic [XLEN-1:0]   alu_operand_a,
    output logic [XLEN-1:0]   alu_operand_b,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_c,
    input  logic              alu_s,
    input  logic              alu_v,
    input  logic              alu_z,
    output logic [3:0]        flags,
    output logic              done,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic              wb_en;
    logic [XLEN-1:0]   rs_data, rt_data;
    logic              instr_unused;

    assign instr_unused = ^instr[RT_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        wb_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d = instr[OP_MSB:OP_LSB];
                    rd_d = instr[RD_MSB:RD_LSB];
                    rs_d = instr[RS_MSB:RS_LSB];
                    rt_d = instr[RT_MSB:RT_LSB];
                    if (op_legal(instr[OP_MSB:OP_LSB])) state_d = ST_ISSUE;
                    else                                illegal_d = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                wb_en           = (rd_q != '0);
                flags_d[FLAG_C] = alu_c;
                flags_d[FLAG_S] = alu_s;
                flags_d[FLAG_V] = alu_v;
                flags_d[FLAG_Z] = alu_z;
                done_d          = 1'b1;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .rs_addr_i    (rs_q),
        .rt_addr_i    (rt_q),
        .dbg_addr_i   (dbg_addr),
        .rs_data_o    (rs_data),
        .rt_data_o    (rt_data),
        .dbg_data_o   (dbg_data),
        .alu_we_i     (wb_en),
        .alu_waddr_i  (rd_q),
        .alu_wdata_i  (alu_result),
        .host_we_i    (hwr_en),
        .host_waddr_i (hwr_addr),
        .host_wdata_i (hwr_data)
    );

    // Operands are only presented during ISSUE so the ALU sees a quiet bus otherwise.
    assign alu_opcode    = (state_q == ST_ISSUE) ? op_q : OP_IDLE;
    assign alu_operand_a = (state_q == ST_ISSUE) ? rs_data : '0;
    assign alu_operand_b = (state_q == ST_ISSUE) ? rt_data : '0;
    assign instr_ready   = (state_q == ST_IDLE);
    assign flags         = flags_q;
    assign done          = done_q;
    assign illegal       = illegal_q;

endmodule
